// File: rtl/wb_arbiter_2m.sv
// Two-master round-robin Wishbone arbiter; the grant locks for the whole CYC of the winner.
// Define WB_ARBITER_TIMEOUT_EN to add a stalled-slave watchdog that aborts with err.
module wb_arbiter_2m #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [AW-1:0] m0_addr_i,
  input  logic          m0_we_i,
  input  logic [DW-1:0] m0_data_i,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  output logic [DW-1:0] m0_data_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  input  logic [AW-1:0] m1_addr_i,
  input  logic          m1_we_i,
  input  logic [DW-1:0] m1_data_i,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  output logic [DW-1:0] m1_data_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic [AW-1:0] s_addr_o,
  output logic          s_we_o,
  output logic [DW-1:0] s_data_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  input  logic [DW-1:0] s_data_i,
  input  logic          s_ack_i,
  output logic [1:0]    gnt_o
);

  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("wb_arbiter_2m: TIMEOUT must be in 1..65535");
  end

  typedef enum logic [1:0] {IDLE = 2'b00, G0 = 2'b01, G1 = 2'b10} state_e;

  state_e state_q, state_d;
  logic   last_q, last_d;
  logic   req0, req1, trip;

`ifdef WB_ARBITER_TIMEOUT_EN
  logic [15:0] wdt_q, wdt_d;
  logic        blk0_q, blk0_d, blk1_q, blk1_d;

  // A master aborted by the watchdog stays locked out until it drops cyc.
  assign req0 = m0_cyc_i & ~blk0_q;
  assign req1 = m1_cyc_i & ~blk1_q;
  assign trip = (state_q != IDLE) && (wdt_q == 16'(TIMEOUT));

  always_comb begin
    wdt_d  = wdt_q;
    blk0_d = blk0_q & m0_cyc_i;
    blk1_d = blk1_q & m1_cyc_i;
    if (state_d != state_q || s_ack_i || state_q == IDLE) begin
      wdt_d = '0;
    end else if (s_stb_o) begin
      wdt_d = wdt_q + 16'd1;
    end
    if (trip && state_q == G0) blk0_d = 1'b1;
    if (trip && state_q == G1) blk1_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wdt_q  <= '0;
      blk0_q <= 1'b0;
      blk1_q <= 1'b0;
    end else begin
      wdt_q  <= wdt_d;
      blk0_q <= blk0_d;
      blk1_q <= blk1_d;
    end
  end
`else
  assign req0 = m0_cyc_i;
  assign req1 = m1_cyc_i;
  assign trip = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Release hands straight over to a waiting master with no IDLE cycle.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (req0 && req1) state_d = last_q ? G0 : G1;
        else if (req0)    state_d = G0;
        else if (req1)    state_d = G1;
      end
      G0: begin
        if (trip || !m0_cyc_i) begin
          last_d  = 1'b0;
          state_d = (!trip && req1) ? G1 : IDLE;
        end
      end
      G1: begin
        if (trip || !m1_cyc_i) begin
          last_d  = 1'b1;
          state_d = (!trip && req0) ? G0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_addr_o  = '0;
    s_we_o    = 1'b0;
    s_data_o  = '0;
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    m0_data_o = '0;
    m0_ack_o  = 1'b0;
    m0_err_o  = 1'b0;
    m1_data_o = '0;
    m1_ack_o  = 1'b0;
    m1_err_o  = 1'b0;
    unique case (state_q)
      G0: begin
        s_addr_o  = m0_addr_i;
        s_we_o    = m0_we_i;
        s_data_o  = m0_data_i;
        s_cyc_o   = m0_cyc_i & ~trip;
        s_stb_o   = m0_stb_i & ~trip;
        m0_data_o = s_data_i;
        m0_ack_o  = s_ack_i & ~trip;
        m0_err_o  = trip;
      end
      G1: begin
        s_addr_o  = m1_addr_i;
        s_we_o    = m1_we_i;
        s_data_o  = m1_data_i;
        s_cyc_o   = m1_cyc_i & ~trip;
        s_stb_o   = m1_stb_i & ~trip;
        m1_data_o = s_data_i;
        m1_ack_o  = s_ack_i & ~trip;
        m1_err_o  = trip;
      end
      default: ;
    endcase
  end

  assign gnt_o = state_q;

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed bench for wb_arbiter_2m; read responses are checked through an expectation queue.
module tb_wb_arbiter_2m;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [AW-1:0] m0_addr_i, m1_addr_i, s_addr_o;
  logic          m0_we_i, m1_we_i, s_we_o;
  logic [DW-1:0] m0_data_i, m1_data_i, m0_data_o, m1_data_o, s_data_o, s_data_i;
  logic          m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i;
  logic          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic          s_cyc_o, s_stb_o, s_ack_i;
  logic [1:0]    gnt_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          m;
    logic [31:0] d;
  } rsp_t;
  rsp_t sb[$];

  always #5 clk_i = ~clk_i;

  wb_arbiter_2m #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i), .m0_data_i(m0_data_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
    .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i), .m1_data_i(m1_data_i),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
    .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_data_o(s_data_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_data_i(s_data_i), .s_ack_i(s_ack_i), .gnt_o(gnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Slave acks with data d; the response must reach the master at the queue head.
  task automatic slave_ack(input logic [31:0] d);
    rsp_t e;
    s_data_i = d;
    s_ack_i  = 1'b1;
    #1;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      if (e.m == 0) begin
        chk("m0_ack", {31'd0, m0_ack_o}, 32'd1);
        chk("m0_data", m0_data_o, e.d);
        chk("m1_ack_quiet", {31'd0, m1_ack_o}, 32'd0);
      end else begin
        chk("m1_ack", {31'd0, m1_ack_o}, 32'd1);
        chk("m1_data", m1_data_o, e.d);
        chk("m0_ack_quiet", {31'd0, m0_ack_o}, 32'd0);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst_i = 1'b1;
    m0_addr_i = '0; m0_we_i = 1'b0; m0_data_i = '0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    m1_addr_i = '0; m1_we_i = 1'b0; m1_data_i = '0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    s_data_i = 32'hDEAD; s_ack_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;

    chk("rst_gnt", {30'd0, gnt_o}, 32'd0);
    chk("rst_s_cyc", {31'd0, s_cyc_o}, 32'd0);
    chk("rst_s_stb", {31'd0, s_stb_o}, 32'd0);
    chk("rst_s_addr", s_addr_o, 32'd0);
    chk("rst_m0_data", m0_data_o, 32'd0);
    chk("rst_m1_data", m1_data_o, 32'd0);
    chk("rst_errs", {30'd0, m0_err_o, m1_err_o}, 32'd0);

    // 1: single read by m0
    m0_addr_i = 32'h10; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    sb.push_back('{0, 32'hA5});
    chk("t1_gnt_latency", {30'd0, gnt_o}, 32'd0);
    tick();
    chk("t1_gnt", {30'd0, gnt_o}, 32'd1);
    chk("t1_s_cyc", {31'd0, s_cyc_o}, 32'd1);
    chk("t1_s_addr", s_addr_o, 32'h10);
    chk("t1_s_we", {31'd0, s_we_o}, 32'd0);
    tick();
    chk("t1_no_early_ack", {31'd0, m0_ack_o}, 32'd0);
    tick();
    slave_ack(32'hA5);
    tick();
    s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    tick();
    chk("t1_idle", {30'd0, gnt_o}, 32'd0);

    // 2: simultaneous requests alternate with direct handoff
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    m0_addr_i = 32'h20; m1_addr_i = 32'h30;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    for (int r = 0; r < 6; r++) sb.push_back('{r % 2, 32'hB0 + 32'(r)});
    for (int r = 0; r < 6; r++) begin
      tick();
      chk("t2_gnt_order", {30'd0, gnt_o}, (r % 2 == 0) ? 32'd1 : 32'd2);
      if (r >= 1 && r <= 4) begin
        if (r % 2 == 0) begin m1_cyc_i = 1'b1; m1_stb_i = 1'b1; end
        else            begin m0_cyc_i = 1'b1; m0_stb_i = 1'b1; end
      end
      slave_ack(32'hB0 + 32'(r));
      tick();
      s_ack_i = 1'b0;
      if (r % 2 == 0) begin m0_cyc_i = 1'b0; m0_stb_i = 1'b0; end
      else            begin m1_cyc_i = 1'b0; m1_stb_i = 1'b0; end
    end
    tick();
    chk("t2_idle", {30'd0, gnt_o}, 32'd0);

    // 3: m0 block write holds the grant while m1 waits
    m0_addr_i = 32'h40; m0_we_i = 1'b1; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    m1_addr_i = 32'h50; m1_we_i = 1'b0; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    for (int i = 0; i < 4; i++) sb.push_back('{0, 32'h0});
    tick();
    chk("t3_gnt", {30'd0, gnt_o}, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      m0_data_i = 32'(i);
      slave_ack(32'h0);
      chk("t3_wdata", s_data_o, 32'(i));
      chk("t3_we", {31'd0, s_we_o}, 32'd1);
      chk("t3_lock", {30'd0, gnt_o}, 32'd1);
      tick();
    end
    s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0;
    chk("t3_still_m0", {30'd0, gnt_o}, 32'd1);
    tick();
    chk("t3_m1_after", {30'd0, gnt_o}, 32'd2);
    chk("t3_m1_addr", s_addr_o, 32'h50);

    // 4: reset while m1 is mid-transaction
    chk("t4_s_cyc_before", {31'd0, s_cyc_o}, 32'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("t4_s_cyc", {31'd0, s_cyc_o}, 32'd0);
    chk("t4_gnt", {30'd0, gnt_o}, 32'd0);
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    tick();
    chk("t4_tie_m0", {30'd0, gnt_o}, 32'd1);
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    tick();
    chk("t4_idle", {30'd0, gnt_o}, 32'd0);

    // 6: stray slave ack while idle
    s_data_i = 32'hEE; s_ack_i = 1'b1;
    #1;
    chk("t6_m0_ack", {31'd0, m0_ack_o}, 32'd0);
    chk("t6_m1_ack", {31'd0, m1_ack_o}, 32'd0);
    chk("t6_m0_data", m0_data_o, 32'd0);
    chk("t6_m1_data", m1_data_o, 32'd0);
    tick();
    s_ack_i = 1'b0;

    // 5: slave never acks m0
    m0_addr_i = 32'h60; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    tick();
    chk("t5_gnt", {30'd0, gnt_o}, 32'd1);
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
`ifdef WB_ARBITER_TIMEOUT_EN
    for (int k = 0; k < 8; k++) begin
      chk("t5_no_err_yet", {31'd0, m0_err_o}, 32'd0);
      chk("t5_s_cyc_held", {31'd0, s_cyc_o}, 32'd1);
      tick();
    end
    chk("t5_err", {31'd0, m0_err_o}, 32'd1);
    chk("t5_s_cyc_drop", {31'd0, s_cyc_o}, 32'd0);
    chk("t5_s_stb_drop", {31'd0, s_stb_o}, 32'd0);
    chk("t5_m1_err", {31'd0, m1_err_o}, 32'd0);
    tick();
    chk("t5_err_pulse", {31'd0, m0_err_o}, 32'd0);
    chk("t5_idle", {30'd0, gnt_o}, 32'd0);
    tick();
    chk("t5_m1_granted", {30'd0, gnt_o}, 32'd2);
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    tick();
    chk("t5_m0_blocked", {30'd0, gnt_o}, 32'd0);
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    tick();
`else
    for (int k = 0; k < 12; k++) begin
      chk("t5_no_err", {31'd0, m0_err_o}, 32'd0);
      chk("t5_held", {30'd0, gnt_o}, 32'd1);
      tick();
    end
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    tick();
    chk("t5_m1_granted", {30'd0, gnt_o}, 32'd2);
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    tick();
    chk("t5_idle", {30'd0, gnt_o}, 32'd0);
`endif

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
